mantissa_divider_seq: RTL
=========================

// Module: mantissa_divider_seq
// PURPOSE
//  Sequential radix-2 restoring divider for significands. It computes Q = floor(dividend*2^N / divisor) plus remainder and sticky.
//  It is the inverse datapath of the Booth/Wallace significand multiplier and sits in the FP divide path, between exponent subtract and normalise/round.
//  It produces one quotient bit per clock, uses a start/busy/done handshake, and is exact (no approximation).
// PARAMETERS
//  N  24  significand width including hidden bit; dividend, divisor and remainder are N bits, quotient is N+1 bits
// PORTS
//  clk          in   1    single clock, rising edge
//  rst_n        in   1    asynchronous, active-low reset
//  start        in   1    request; sampled only while busy==0
//  dividend     in   N    unsigned significand A, captured on the accepted start
//  divisor      in   N    unsigned significand D, captured on the accepted start
//  busy         out  1    high from the cycle after an accepted start until done is asserted
//  done         out  1    single-cycle pulse: results valid
//  quotient     out  N+1  Q, weight 2^N at MSB (Q/2^N is the real quotient)
//  remainder    out  N    A*2^N - Q*D, always < D
//  sticky       out  1    |remainder
//  div_by_zero  out  1    divisor==0 on the accepted start
//  overflow     out  1    dividend >= 2*divisor on the accepted start (Q would not fit)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; every output 0; internal R, D, Q, count all 0.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: on start, capture A and D.
//    - D==0: set div_by_zero, go to DONE.
//    - else {1'b0,A} >= {D,1'b0}: set overflow, go to DONE.
//    - else: R=A (N+1 bits), Q=0, count=N, go to CALC.
//    - Flags clear on every accepted start.
//   CALC, one iteration per clock:
//    - bit = (R >= D)
//    - Q = {Q[N-1:0], bit}
//    - Rn = bit ? R-D : R
//    - if count==0: remainder = Rn[N-1:0], go to DONE
//    - else: R = Rn<<1, count--
//    - R never exceeds N+1 bits, because A < 2D is guaranteed on entry.
//   DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
//  Latency:
//   - Normal: done is high in cycle N+2 after the start-sampling edge (cycle 0). For N=24 this is cycle 26.
//   - div_by_zero/overflow: done is high in cycle 1.
//  Error results:
//   - div_by_zero or overflow: quotient = all ones, remainder = 0, sticky = 1.
//  Holding:
//   - quotient/remainder/sticky/flags hold their values after done until the next accepted start.
//   - They are not guaranteed meaningful while busy.
//  busy = (state==CALC).
//  start while busy, or in the DONE cycle, is ignored (not queued). start held high in IDLE re-triggers every operation.
//  Inputs are captured once; dividend/divisor may change freely after the accepted start.
//  Reset mid-operation aborts immediately to the reset state; no done pulse follows.
// TESTING
//  1) A=24'h800000, D=24'h800000, start@0 -> done@26; Q=25'h1000000, rem=0, sticky=0, busy high cycles 1..25
//  2) A=24'hC00000, D=24'h800000 -> Q=25'h1800000, rem=0, sticky=0
//  3) A=24'h800000, D=24'hC00000 -> Q=25'h0AAAAAA, rem=24'h800000, sticky=1
//  4) D=0, A=24'h800000 -> done@1, div_by_zero=1, Q=25'h1FFFFFF, sticky=1; A=24'hFFFFFF, D=24'h000001 -> overflow=1, done@1
//  5) start re-pulsed at cycles 5 and 10 with other operands during case 1 -> ignored; result still equals case 1, single done pulse
//  6) rst_n low at cycle 10 of case 3 -> all outputs 0 immediately, no done; after release, case 2 completes correctly in 26 cycles

Source files
------------

// File: rtl/mantissa_divider_seq.sv
// Sequential radix-2 restoring divider for significands: Q = floor(A*2^N / D),
// one quotient bit per clock, with exact remainder and sticky.
module mantissa_divider_seq #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N:0]   quotient,
    output logic [N-1:0] remainder,
    output logic         sticky,
    output logic         div_by_zero,
    output logic         overflow,
    output logic [1:0]   fsm_state
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N:0]     r;
    logic [N-1:0]   d;
    logic [CW-1:0]  count;

    logic           q_bit;
    logic [N:0]     rn;

    // Handshake: start is sampled only in IDLE; busy is high exactly while in CALC;
    // done is a one-cycle pulse in DONE, after which results hold until the next accepted start.
    always_comb begin
        q_bit = (r >= {1'b0, d});
        rn    = q_bit ? (r - {1'b0, d}) : r;
    end

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            d           <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            sticky      <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        d           <= divisor;
                        remainder   <= '0;
                        sticky      <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (divisor == '0) begin
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            sticky      <= 1'b1;
                            r           <= '0;
                            count       <= '0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if ({1'b0, dividend} >= {divisor, 1'b0}) begin
                            // A >= 2D: the quotient would need more than N+1 bits.
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            sticky      <= 1'b1;
                            r           <= '0;
                            count       <= '0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            r        <= {1'b0, dividend};
                            quotient <= '0;
                            count    <= CW'(N);
                            busy     <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    quotient <= {quotient[N-1:0], q_bit};
                    if (count == '0) begin
                        remainder <= rn[N-1:0];
                        sticky    <= |rn[N-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // rn < D always, so the shifted partial remainder fits N+1 bits.
                        r     <= rn << 1;
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
